// File: rtl/tmds_soft_serializer_if.sv
// Parallel word handshake into tmds_soft_serializer: valid/ready plus lane-packed data.
// Lane c occupies in_data[c*DATA_WIDTH +: DATA_WIDTH].
interface tmds_soft_serializer_if #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned CHANNELS   = 3
);
  logic                           in_valid;
  logic                           in_ready;
  logic [CHANNELS*DATA_WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/tmds_soft_serializer.sv
// Fabric-only N:1 serializer on the bit clock with one-entry holding register and idle-word insertion.
// Optional training-word mode is enabled by defining SER_TRAIN_EN (adds the train_i port).
module tmds_soft_serializer #(
  parameter int unsigned            DATA_WIDTH = 10,
  parameter int unsigned            CHANNELS   = 3,
  parameter bit                     MSB_FIRST  = 1'b0,
  parameter logic [DATA_WIDTH-1:0]  IDLE_WORD  = 10'b1101010100,
  parameter logic [DATA_WIDTH-1:0]  TRAIN_WORD = 10'b0000011111
) (
  input  logic                clk_serial_i,
  input  logic                rst_i,
  tmds_soft_serializer_if.slave in_if,
`ifdef SER_TRAIN_EN
  input  logic                train_i,
`endif
  output logic [CHANNELS-1:0] ser_out_o,
  output logic                word_start_o,
  output logic                underflow_o
);

  localparam int unsigned    CW       = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DATA_WIDTH - 1);

  logic [CW-1:0]                        cnt_q, cnt_d;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0]  shreg_q, shreg_d;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0]  hold_q, hold_d;
  logic                                 hold_full_q, hold_full_d;
  logic                                 underflow_q, underflow_d;
  logic                                 load_edge;
  logic                                 train_w;
  logic                                 accept;

`ifdef SER_TRAIN_EN
  assign train_w = train_i;
`else
  assign train_w = 1'b0;
`endif

  assign load_edge = (cnt_q == CNT_LAST);

  // While training, the held word is not drained, so ready only reflects an empty hold.
  assign in_if.in_ready = !rst_i && (!hold_full_q || (load_edge && !train_w));
  assign accept         = in_if.in_valid && in_if.in_ready;

  always_comb begin
    cnt_d       = load_edge ? '0 : cnt_q + CW'(1);
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    underflow_d = 1'b0;

    if (load_edge) begin
      if (train_w) begin
        for (int c = 0; c < int'(CHANNELS); c++) shreg_d[c] = TRAIN_WORD;
      end else if (hold_full_q) begin
        shreg_d     = hold_q;
        hold_full_d = 1'b0;
      end else begin
        for (int c = 0; c < int'(CHANNELS); c++) shreg_d[c] = IDLE_WORD;
        underflow_d = 1'b1;
      end
    end else begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        if (MSB_FIRST) shreg_d[c] = {shreg_q[c][DATA_WIDTH-2:0], 1'b0};
        else           shreg_d[c] = {1'b0, shreg_q[c][DATA_WIDTH-1:1]};
      end
    end

    // Accept after drain so a simultaneous drain+accept keeps hold_full set.
    if (accept) begin
      hold_d      = in_if.in_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_serial_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      shreg_q     <= {CHANNELS{IDLE_WORD}};
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    ser_out_o = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      ser_out_o[c] = MSB_FIRST ? shreg_q[c][DATA_WIDTH-1] : shreg_q[c][0];
    end
  end

  assign word_start_o = (cnt_q == '0);
  assign underflow_o  = underflow_q;

endmodule
